ysyx22041405_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage buffer for the NPC core, replacing the fixed single-entry write-enable stage registers between IFU/IDU/EXU. Holds up to DEPTH stage messages in a circular buffer with valid/ready handshakes on both sides, a synchronous flush for redirects, and an occupancy count. Upstream stalls only when the buffer is full. Downstream back-pressure never reaches `in_ready` combinationally.

---
 rtl/ysyx22041405_stage_buf.sv | 84 ++++++++
 tb/tb_ysyx22041405_stage_buf.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready on both sides.
// Optional STAGE_BUF_STALL_CNT_EN adds a saturating 32-bit back-pressure cycle counter.
module ysyx22041405_stage_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef STAGE_BUF_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic             empty, full, push, pop;

  // The extra top pointer bit separates full from empty when the low bits match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = wp_q - rp_q;
  assign out_data  = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = wp_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rp_d = rp_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wp_q[AW-1:0]] <= in_data;
    end
  end

`ifdef STAGE_BUF_STALL_CNT_EN
  logic stall;
  assign stall = (out_valid & ~out_ready) | (in_valid & ~in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx22041405_stage_buf.sv
// Scoreboard bench for ysyx22041405_stage_buf: a queue model updated on each edge,
// a negedge monitor comparing every DUT output against it.
module tb_ysyx22041405_stage_buf;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
`ifdef STAGE_BUF_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  ysyx22041405_stage_buf #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
`ifdef STAGE_BUF_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  logic [W-1:0] exp_q[$];
  longint unsigned exp_stall;
  int  checks   = 0;
  int  failures = 0;
  int  delivered = 0;
  bit  mon_en   = 0;
  bit  m_full, m_empty;

  // Reference model: occupancy is just the length of a queue of messages.
  always @(posedge clk) begin
    m_full  = (exp_q.size() == D);
    m_empty = (exp_q.size() == 0);
    if (rst) begin
      exp_q.delete();
      exp_stall = 0;
      mon_en    = 1;
    end else begin
      if (((!m_empty && !out_ready) || (in_valid && m_full)) && exp_stall != 64'hFFFF_FFFF)
        exp_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (!m_empty && out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (in_valid && !m_full) exp_q.push_back(in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
      chk("in_ready",  W'(in_ready),  W'(exp_q.size() != D));
      chk("count",     W'(count),     W'(exp_q.size()));
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
`ifdef STAGE_BUF_STALL_CNT_EN
      chk("stall_cnt", W'(stall_cnt), W'(exp_stall));
`endif
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill with a stalled consumer, attempt a push while full, then drain in order.
    drive(1, 64'h11, 0, 0);
    drive(1, 64'h22, 0, 0);
    drive(1, 64'h33, 0, 0);
    drive(1, 64'h44, 0, 0);
    drive(1, 64'h55, 0, 0);
    drive(1, 64'h55, 0, 0);
    repeat (5) drive(0, '0, 1, 0);

    // Streaming: one message per cycle, pointers wrap several times.
    for (int i = 1; i <= 10; i++) drive(1, W'(i), 1, 0);
    repeat (2) drive(0, '0, 1, 0);

    // Simultaneous push/pop at count=2, then full with both asserted.
    drive(1, 64'h61, 0, 0);
    drive(1, 64'h62, 0, 0);
    drive(1, 64'h63, 1, 0);
    drive(1, 64'h64, 0, 0);
    drive(1, 64'h65, 0, 0);
    drive(1, 64'h77, 1, 0);

    // Flush at count=3 with a concurrent push, then push right after.
    drive(1, 64'hAA, 0, 1);
    drive(1, 64'hBB, 0, 0);
    repeat (2) drive(0, '0, 1, 0);

    // Back-pressure counter: clean reset, one entry held for 7 cycles, flush, reset.
    rst = 1'b1;
    drive(0, '0, 0, 0);
    rst = 1'b0;
    drive(1, 64'hC0, 0, 0);
    repeat (7) drive(0, '0, 0, 0);
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    rst = 1'b1;
    drive(0, '0, 0, 0);
    rst = 1'b0;

    // Randomised traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    repeat (D + 1) drive(0, '0, 1, 0);

    @(negedge clk);
    checks++;
    if (delivered < 100) begin
      failures++;
      $display("FAIL delivered: got %0d transfers expected at least 100", delivered);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
